mux_arb_n: RTL

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_pick.sv | 37 +++
 rtl/mux_arb_n.sv | 92 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel mux/arbiter: mode encodings and a
// ceiling-log2 helper used to size select and index fields.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, never less than 1 so a 2-channel select still has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first asserted request at or after ptr, wrapping
// from N-1 back to 0.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap subtract.
  localparam int unsigned IW = SELW + 1;

  logic [IW-1:0] w_idx;

  // Walk the N positions starting at ptr and keep the first requester found.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, ptr} + IW'(k);
      if (w_idx >= IW'(N)) begin
        w_idx = w_idx - IW'(N);
      end
      if (!grant_valid && req[w_idx[SELW-1:0]]) begin
        grant       = w_idx[SELW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with a one-entry registered output.
// Mode selects a fixed channel index or round-robin arbitration.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 4,
  localparam int unsigned SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic             r_out_valid;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic [SELW-1:0]  w_rr_grant;
  logic             w_rr_valid;
  logic             w_sel_ok;
  logic             w_fix_valid;
  logic [SELW-1:0]  w_grant;
  logic             w_grant_valid;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_nxt;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req         (in_valid),
    .ptr         (r_rr_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  // The output slot can take a new entry when empty or being drained.
  assign w_load_en   = !r_out_valid || out_ready;
  // An out-of-range select must never grant, even if the index aliases a bit.
  assign w_sel_ok    = (32'(sel) < N);
  assign w_fix_valid = w_sel_ok && in_valid[sel];

  assign w_grant       = (mode == MODE_RR) ? w_rr_grant : sel;
  assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
  assign w_xfer        = rst_n && w_load_en && w_grant_valid;
  assign w_ptr_nxt     = (w_grant == SELW'(N - 1)) ? '0 : w_grant + 1'b1;

  // Ready goes only to the granted channel, and only when a load will happen.
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  // Output entry and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_grant_valid) begin
        r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
        r_out_src   <= w_grant;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          r_rr_ptr <= w_ptr_nxt;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule
